tx_axis_arbiter: RTL and testbench

Frame-granular arbiter that shares the single 32-bit TX MAC AXIS input between NUM_PORTS upstream AXIS frame sources. A grant is held from the first beat to the TLAST beat of one frame, so frames never interleave. Output passes through a 2-entry skid buffer so timing into the MAC is registered. Sits between the user/application streams and the TX MAC, mirroring the RX MAC's 32-bit AXIS conventions.

---
 rtl/tx_axis_arbiter.sv | 152 +++++++++++++++
 tb/tb_tx_axis_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_axis_arbiter.sv
// Frame-granular round-robin arbiter feeding the 32-bit TX MAC AXIS input through a 2-entry skid buffer.
// Define TX_ARB_STRICT_PRIO_EN to replace round robin with strict lowest-index priority.
module tx_axis_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_PORTS*32-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS*4-1:0]    s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]      s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]      s_axis_tlast,
  output logic [NUM_PORTS-1:0]      s_axis_tready,
  output logic [31:0]               m00_axis_tdata,
  output logic [3:0]                m00_axis_tkeep,
  output logic                      m00_axis_tvalid,
  output logic                      m00_axis_tlast,
  input  logic                      m00_axis_tready,
  output logic [NUM_PORTS-1:0]      o_grant,
  output logic                      o_frame_active
);
  localparam int DATA_WIDTH  = 32;
  localparam int DATA_NBYTES = 4;
  localparam int IW          = $clog2(NUM_PORTS);
  localparam int EW          = DATA_WIDTH + DATA_NBYTES + 1;

  typedef enum logic {IDLE, XFER} state_e;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IW-1:0]        last_q, last_d;
  logic [EW-1:0]        buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]           count_q, count_d;
  logic [EW-1:0]        sel_beat;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        gnt_idx;
  logic                 buf_full;
  logic                 push;
  logic                 pop;
  int                   rr_idx;

  // Winner for the next frame, evaluated every cycle but only used in IDLE.
  always_comb begin
    win_idx = '0;
    rr_idx  = 0;
`ifdef TX_ARB_STRICT_PRIO_EN
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (s_axis_tvalid[i]) win_idx = IW'(i);
    end
`else
    for (int k = NUM_PORTS; k >= 1; k--) begin
      rr_idx = (int'(last_q) + k) % NUM_PORTS;
      if (s_axis_tvalid[rr_idx]) win_idx = IW'(rr_idx);
    end
`endif
  end

  always_comb begin
    sel_beat = '0;
    gnt_idx  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_q[p]) begin
        sel_beat = {s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH],
                    s_axis_tkeep[p*DATA_NBYTES +: DATA_NBYTES],
                    s_axis_tlast[p]};
        gnt_idx  = IW'(p);
      end
    end
  end

  // Handshakes: a beat moves on any interface exactly when tvalid and tready are
  // both high at a rising clock edge; tvalid never waits on tready.
  assign buf_full      = (count_q == 2'd2);
  assign s_axis_tready = (state_q == XFER && !buf_full) ? grant_q : '0;
  assign push          = |(s_axis_tvalid & s_axis_tready);
  assign pop           = m00_axis_tvalid & m00_axis_tready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|s_axis_tvalid) begin
          state_d          = XFER;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
        end
      end
      XFER: begin
        if (push && sel_beat[0]) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gnt_idx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Head entry holds its value when the buffer empties, so outputs stay stable.
  always_comb begin
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) buf0_d = sel_beat;
        else                 buf1_d = sel_beat;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) buf0_d = buf1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          buf0_d = buf1_q;
          buf1_d = sel_beat;
        end else begin
          buf0_d = sel_beat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_PORTS - 1);
      buf0_q  <= '0;
      buf1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      count_q <= count_d;
    end
  end

  assign m00_axis_tdata  = buf0_q[EW-1 -: DATA_WIDTH];
  assign m00_axis_tkeep  = buf0_q[DATA_NBYTES:1];
  assign m00_axis_tlast  = buf0_q[0];
  assign m00_axis_tvalid = (count_q != 2'd0);
  assign o_grant         = grant_q;
  assign o_frame_active  = (state_q == XFER);

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// Bench for tx_axis_arbiter: frame-level behavioural model checked every cycle plus directed frame streams.
module tb_tx_axis_arbiter;
  localparam int NP = 2;
  localparam int W  = 37;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic [NP*32-1:0]  s_tdata;
  logic [NP*4-1:0]   s_tkeep;
  logic [NP-1:0]     s_tvalid;
  logic [NP-1:0]     s_tlast;
  logic [NP-1:0]     s_tready;
  logic [31:0]       m_tdata;
  logic [3:0]        m_tkeep;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic [NP-1:0]     o_grant;
  logic              o_frame_active;

  tx_axis_arbiter #(.NUM_PORTS(NP)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .s_axis_tdata    (s_tdata),
    .s_axis_tkeep    (s_tkeep),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tlast    (s_tlast),
    .s_axis_tready   (s_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tkeep  (m_tkeep),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tready (m_tready),
    .o_grant         (o_grant),
    .o_frame_active  (o_frame_active)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- bookkeeping ----------------
  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [W-1:0]  src_q [NP][$];
  int            gap_q [NP][$];
  logic          rdy_q [$];
  logic [W-1:0]  exp_q [$];
  logic [W-1:0]  out_q [$];
  logic [NP-1:0] hs = '0;

  // model: granted port (-1 none), last served port, buffered beats
  int            mg    = -1;
  int            mlast = NP - 1;
  logic [W-1:0]  mbuf [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NP-1:0] v, input int last);
`ifdef TX_ARB_STRICT_PRIO_EN
    for (int i = 0; i < NP; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NP; k++) if (v[(last + k) % NP]) return (last + k) % NP;
`endif
    return -1;
  endfunction

  // ---------------- compare process + model ----------------
  logic [NP-1:0] e_grant;
  logic [NP-1:0] e_rdy;
  logic          m_acc;
  logic          m_pop;
  logic [W-1:0]  m_beat;

  always @(negedge i_clk) begin
    e_grant = '0;
    if (mg >= 0) e_grant[mg] = 1'b1;
    e_rdy = (mbuf.size() < 2) ? e_grant : '0;
    check("o_grant", o_grant, e_grant);
    check("o_frame_active", o_frame_active, mg >= 0);
    check("s_tready", s_tready, e_rdy);
    check("m_tvalid", m_tvalid, mbuf.size() != 0);
    if (mbuf.size() != 0) check("m_beat", {m_tdata, m_tkeep, m_tlast}, mbuf[0]);

    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) out_q.push_back({m_tdata, m_tkeep, m_tlast});

    if (i_reset) begin
      mg = -1;
      mlast = NP - 1;
      mbuf.delete();
    end else begin
      m_acc  = (mg >= 0) && (mbuf.size() < 2) && s_tvalid[mg];
      m_pop  = (mbuf.size() != 0) && m_tready;
      m_beat = '0;
      if (mg >= 0) m_beat = {s_tdata[mg*32 +: 32], s_tkeep[mg*4 +: 4], s_tlast[mg]};
      if (m_pop) void'(mbuf.pop_front());
      if (m_acc) mbuf.push_back(m_beat);
      if (mg < 0) begin
        if (|s_tvalid) mg = pick(s_tvalid, mlast);
      end else if (m_acc && s_tlast[mg]) begin
        mlast = mg;
        mg = -1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() != 0 && gap_q[p][0] == 0) begin
        {s_tdata[p*32 +: 32], s_tkeep[p*4 +: 4], s_tlast[p]} = src_q[p][0];
        s_tvalid[p] = 1'b1;
      end else begin
        s_tdata[p*32 +: 32] = '0;
        s_tkeep[p*4 +: 4]   = '0;
        s_tlast[p]          = 1'b0;
        s_tvalid[p]         = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge i_clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) begin
        void'(src_q[p].pop_front());
        void'(gap_q[p].pop_front());
      end else if (src_q[p].size() != 0 && gap_q[p][0] > 0) begin
        gap_q[p][0] = gap_q[p][0] - 1;
      end
    end
    m_tready = (rdy_q.size() != 0) ? rdy_q.pop_front() : 1'b1;
    drive_inputs();
  endtask

  task automatic load_frame(input int p, input logic [31:0] base, input logic [31:0] step,
                            input int n, input logic [3:0] lkeep, input int gap_at, input int gap_len);
    for (int i = 0; i < n; i++) begin
      src_q[p].push_back({base + step * i, (i == n - 1) ? lkeep : 4'hF, i == n - 1});
      gap_q[p].push_back((i == gap_at) ? gap_len : 0);
    end
  endtask

  task automatic expect_frame(input logic [31:0] base, input logic [31:0] step,
                              input int n, input logic [3:0] lkeep);
    for (int i = 0; i < n; i++)
      exp_q.push_back({base + step * i, (i == n - 1) ? lkeep : 4'hF, i == n - 1});
  endtask

  task automatic run_until_idle(input string name);
    int n = 0;
    while ((src_q[0].size() != 0 || src_q[1].size() != 0 || mbuf.size() != 0 || mg >= 0) && n < 300) begin
      cycle();
      n++;
    end
    check({name, "_done_in_budget"}, n < 300, 1'b1);
    cycle();
  endtask

  task automatic check_stream(input string name);
    check({name, "_beats"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < out_q.size()) check({name, "_stream"}, out_q[i], exp_q[i]);
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_m_tvalid"}, m_tvalid, 1'b0);
    check({name, "_m_tdata"}, m_tdata, 32'h0);
    check({name, "_m_tkeep"}, m_tkeep, 4'h0);
    check({name, "_m_tlast"}, m_tlast, 1'b0);
    check({name, "_o_grant"}, o_grant, 2'b00);
    check({name, "_s_tready"}, s_tready, 2'b00);
    check({name, "_frame_active"}, o_frame_active, 1'b0);
  endtask

  task automatic apply_reset();
    i_reset = 1'b1;
    cycle();
    cycle();
    check_all_zero("reset");
    i_reset = 1'b0;
    out_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    i_reset  = 1'b1;
    m_tready = 1'b1;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    apply_reset();

    // single frame: first output beat two cycles after tvalid
    load_frame(0, 32'h11111111, 32'h11111111, 4, 4'h3, -1, 0);
    expect_frame(32'h11111111, 32'h11111111, 4, 4'h3);
    drive_inputs();
    cycle();
    check("single_grant_n1", o_grant, 2'b01);
    check("single_tvalid_n1", m_tvalid, 1'b0);
    cycle();
    check("single_tvalid_n2", m_tvalid, 1'b1);
    check("single_tdata_n2", m_tdata, 32'h11111111);
    run_until_idle("single");
    check_stream("single");

    // two ports competing with two 3-beat frames each
    apply_reset();
    load_frame(0, 32'hA0000000, 32'h1, 3, 4'hF, -1, 0);
    load_frame(0, 32'hA0000010, 32'h1, 3, 4'h1, -1, 0);
    load_frame(1, 32'hB0000000, 32'h1, 3, 4'h7, -1, 0);
    load_frame(1, 32'hB0000010, 32'h1, 3, 4'h0, -1, 0);
`ifdef TX_ARB_STRICT_PRIO_EN
    expect_frame(32'hA0000000, 32'h1, 3, 4'hF);
    expect_frame(32'hA0000010, 32'h1, 3, 4'h1);
    expect_frame(32'hB0000000, 32'h1, 3, 4'h7);
    expect_frame(32'hB0000010, 32'h1, 3, 4'h0);
`else
    expect_frame(32'hA0000000, 32'h1, 3, 4'hF);
    expect_frame(32'hB0000000, 32'h1, 3, 4'h7);
    expect_frame(32'hA0000010, 32'h1, 3, 4'h1);
    expect_frame(32'hB0000010, 32'h1, 3, 4'h0);
`endif
    drive_inputs();
    run_until_idle("arb");
    check_stream("arb");

    // backpressure: downstream ready toggles 1,0,0,1
    for (int i = 0; i < 8; i++) begin
      rdy_q.push_back(1'b1);
      rdy_q.push_back(1'b0);
      rdy_q.push_back(1'b0);
      rdy_q.push_back(1'b1);
    end
    load_frame(0, 32'hC0000000, 32'h1, 6, 4'h3, -1, 0);
    expect_frame(32'hC0000000, 32'h1, 6, 4'h3);
    drive_inputs();
    run_until_idle("bp");
    rdy_q.delete();
    m_tready = 1'b1;
    check_stream("bp");

    // reset in the middle of a 5-beat frame
    load_frame(0, 32'hD0000000, 32'h1, 5, 4'hF, -1, 0);
    drive_inputs();
    n = 0;
    while (src_q[0].size() > 3 && n < 50) begin
      cycle();
      n++;
    end
    check("midreset_two_beats_taken", src_q[0].size(), 3);
    i_reset = 1'b1;
    cycle();
    check_all_zero("midreset");
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      gap_q[p].delete();
    end
    drive_inputs();
    i_reset = 1'b0;
    cycle();
    out_q.delete();
    exp_q.delete();
    load_frame(0, 32'hE0000000, 32'h1, 4, 4'hF, -1, 0);
    expect_frame(32'hE0000000, 32'h1, 4, 4'hF);
    drive_inputs();
    cycle();
    check("postreset_grant", o_grant, 2'b01);
    run_until_idle("postreset");
    check_stream("postreset");

    // granted port stalls 3 cycles mid-frame while port 1 waits
    apply_reset();
    load_frame(0, 32'hF0000000, 32'h1, 5, 4'hF, 2, 3);
    load_frame(1, 32'h90000000, 32'h1, 3, 4'hC, -1, 0);
    expect_frame(32'hF0000000, 32'h1, 5, 4'hF);
    expect_frame(32'h90000000, 32'h1, 3, 4'hC);
    drive_inputs();
    n = 0;
    while (src_q[0].size() > 3 && n < 50) begin
      cycle();
      n++;
    end
    cycle();
    check("stall_tvalid_low", s_tvalid, 2'b10);
    check("stall_grant_held", o_grant, 2'b01);
    check("stall_tready_held", s_tready, 2'b01);
    run_until_idle("stall");
    check_stream("stall");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
